// File: rtl/spi_rom_responder.sv
// spi_rom_responder: SPI mode-0 0x02/0x03 flash-protocol target over a word memory.
// Optional macro SPI_RESP_READ_ID_EN adds the 0x9F JEDEC ID response.
`timescale 1ns/1ps
module spi_rom_responder #(
  parameter int          ADDR_W   = 8,
  parameter logic [23:0] ID_VALUE = 24'hEF4016
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [7:0]  last_cmd,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    RD   = 3'd3,
    WR   = 3'd4,
`ifdef SPI_RESP_READ_ID_EN
    ID   = 3'd6,
`endif
    IGN  = 3'd5
  } state_t;

  state_t state;
  state_t state_n;

  logic sck_s1;
  logic sck_s2;
  logic sck_d;
  logic cs_s1;
  logic cs_s2;
  logic cs_d;
  logic mosi_s1;
  logic mosi_s2;

  logic sck_rise;
  logic sck_fall;
  logic cs_fall;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_sr;
  logic [6:0]        cmd_sr;
  logic [7:0]        cmd_word;
  logic [30:0]       rx_sr;
  logic [31:0]       rx_word;
  logic [31:0]       tx_sr;
  logic [4:0]        bit_cnt;
  logic              fetch;
  logic              rd_cmd;
  logic              mem_we;
`ifdef SPI_RESP_READ_ID_EN
  logic [23:0]       id_sr;
`endif

  logic [31:0] mem [DEPTH];

  // Two-flop synchronizers plus a delayed sck/cs copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_d   <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_d   <= sck_s2;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign cs_fall  = ~cs_s2 & cs_d;

  assign cmd_word = {cmd_sr, mosi_s2};
  assign rx_word  = {rx_sr, mosi_s2};
  assign rd_cmd   = (last_cmd == 8'h03);

  assign mem_we = ~rst & (state == WR) & sck_rise
                & (bit_cnt == 5'd31);

  // Word memory; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr] <= rx_word;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: cs high always returns to IDLE
  always_comb begin
    state_n = state;
    if (cs_s2) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (cs_fall) state_n = CMD;
        end
        CMD: begin
          if (sck_rise && bit_cnt == 5'd7) begin
            case (cmd_word)
              8'h02:   state_n = ADDR;
              8'h03:   state_n = ADDR;
`ifdef SPI_RESP_READ_ID_EN
              8'h9F:   state_n = ID;
`endif
              default: state_n = IGN;
            endcase
          end
        end
        ADDR: begin
          if (sck_rise && bit_cnt == 5'd23) begin
            state_n = rd_cmd ? RD : WR;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // Datapath: shift registers, pointer, counters and serial output
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      addr_sr  <= '0;
      cmd_sr   <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      bit_cnt  <= '0;
      fetch    <= 1'b0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      last_cmd <= '0;
      wr_count <= '0;
`ifdef SPI_RESP_READ_ID_EN
      id_sr    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
        end
        CMD: begin
          if (sck_rise) begin
            cmd_sr  <= cmd_word[6:0];
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              last_cmd <= cmd_word;
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt < 5'd22) begin
              addr_sr <= {addr_sr[ADDR_W-2:0], mosi_s2};
            end
            if (bit_cnt == 5'd23) begin
              ptr <= addr_sr;
            end
          end
        end
        RD: begin
          if (fetch) begin
            tx_sr <= mem[ptr];
            ptr   <= ptr + ADDR_W'(1);
            fetch <= 1'b0;
          end else if (sck_fall) begin
            miso    <= tx_sr[31];
            miso_oe <= 1'b1;
            tx_sr   <= {tx_sr[30:0], 1'b0};
            if (bit_cnt == 5'd31) begin
              bit_cnt <= '0;
              fetch   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        WR: begin
          if (sck_rise) begin
            rx_sr <= rx_word[30:0];
            if (bit_cnt == 5'd31) begin
              bit_cnt <= '0;
              ptr     <= ptr + ADDR_W'(1);
              if (wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
`ifdef SPI_RESP_READ_ID_EN
        ID: begin
          if (sck_fall) begin
            miso    <= id_sr[23];
            miso_oe <= 1'b1;
            id_sr   <= {id_sr[22:0], 1'b0};
          end
        end
`endif
        IGN: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
        end
        default: begin
          miso    <= 1'b0;
          miso_oe <= 1'b0;
        end
      endcase

      if (state_n != state) begin
        bit_cnt <= '0;
        fetch   <= (state_n == RD);
`ifdef SPI_RESP_READ_ID_EN
        if (state_n == ID) begin
          id_sr <= ID_VALUE;
        end
`endif
      end

      if (state_n == IDLE || state_n == IGN) begin
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end
    end
  end

endmodule

// File: doc/spi_rom_responder.md
# spi_rom_responder

Synthesizable SPI mode-0 target that answers the 0x02 write / 0x03 read flash protocol driven by the team's SPI master: 8-bit command, 24-bit byte address, then 32-bit data words, MSB first. It oversamples `sck`/`cs`/`mosi` on the system clock and backs them with an internal word memory. It serves as the on-chip memory model for SPI ROM bring-up and as the device-under-test partner for the master.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; memory depth is 2^ADDR_W 32-bit words.
- `ID_VALUE`, 24'hEF4016: JEDEC ID returned by 0x9F (only with `SPI_RESP_READ_ID_EN`).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; every flop is on its rising edge.
- `rst` in 1: synchronous active-high reset.
- `sck` in 1: SPI clock from master, asynchronous to `clk`, idle low.
- `cs` in 1: chip select, active low, asynchronous.
- `mosi` in 1: serial data from master.
- `miso` out 1: serial data to master.
- `miso_oe` out 1: high while the block drives meaningful read data.
- `last_cmd` out 8: last fully received command byte.
- `wr_count` out 16: number of 32-bit words committed to memory, saturates at 16'hFFFF.

## Operation
- `sck`, `cs` and `mosi` pass through 2-flop synchronizers. `sck_rise`/`sck_fall` are single-cycle pulses from the synchronized `sck` against its delayed copy. `mosi` is sampled from its synchronized copy in the `sck_rise` cycle.
- States:
  - `IDLE`: `cs` high.
  - `CMD`: 8 bits.
  - `ADDR`: 24 bits.
  - `RD`: read data phase.
  - `WR`: write data phase.
  - `ID`: only with the macro.
  - `IGN`: ignore rest of the transfer.
- `IDLE`→`CMD` on synchronized `cs` falling. The bit counter resets to 0 on every state entry.
- `CMD`: after the 8th `sck_rise`, latch `last_cmd`.
  - 0x02 or 0x03 → `ADDR`.
  - 0x9F → `ID` (macro only).
  - Anything else → `IGN`.
- `ADDR`: after 24 bits, word pointer = addr[ADDR_W+1:2]. addr[1:0] and addr[23:ADDR_W+2] are ignored. Then enter `RD` (0x03) or `WR` (0x02).
- `RD`:
  - In the cycle after entry, load `mem[ptr]` into the 32-bit TX shift register and increment `ptr`.
  - On each `sck_fall`, present the next bit on `miso`, MSB first. The first bit appears on the falling edge that follows the last address bit.
  - After 32 bits, reload from the new `ptr` and continue. Output is continuous while `cs` stays low.
- `WR`:
  - Shift `mosi` into the RX register on each `sck_rise`.
  - At the 32nd bit, write the word to `mem[ptr]`, increment `ptr`, increment `wr_count`, and restart the bit count.
- `IGN`: `miso` low, `miso_oe` low, no memory access.
- `ptr` wraps modulo 2^ADDR_W; there are no boundary errors.
- Synchronized `cs` high in any state → `IDLE` on the next clock:
  - An incomplete RX word is discarded, not written.
  - An incomplete command or address has no effect.
  - `miso` and `miso_oe` return to 0.
- Reset values: `miso`=0, `miso_oe`=0, `last_cmd`=0, `wr_count`=0, state `IDLE`, `ptr`=0.
- Memory content is not reset; it is initialised to 0 only at configuration.

## Timing
- Minimum `clk`:`sck` ratio is 6:1. Each `sck` half period must be at least 3 `clk` cycles.
- Pad edge to internal `sck_rise`/`sck_fall` pulse: 3 `clk` cycles (2 sync plus 1 edge detect).
- Read word fetch: 1 `clk` after the last address bit's `sck_rise`. This is ready before the following `sck_fall`.
- `miso` updates 3–4 `clk` after the `sck` falling pad edge. The master samples on the next rising edge.
- `miso_oe` rises with the first data bit in `RD`/`ID` and falls 3 `clk` after `cs` goes high.
- Memory write and `wr_count` increment happen 1 `clk` after the 32nd data `sck_rise` of a word.
- `cs` high pulses shorter than 3 `clk` may be missed. The master must hold `cs` high for at least 3 `clk`.
- A `cs` deassert that arrives in the same cycle as a word-completing `sck_rise` still commits the word; completion wins.

## Configuration
- Macro `SPI_RESP_READ_ID_EN`.
- With the macro: command 0x9F enters `ID`, which shifts out `ID_VALUE` MSB first on `sck_fall`, 24 bits. After that, `miso`=0 with `miso_oe` still high until `cs` rises.
- Without the macro: the `ID` state and its logic are absent, and 0x9F → `IGN` like any unknown command.

## Test plan
- Write then read:
  - Send 0x02, addr 0x000010, data 0xDEADBEEF; `cs` high.
  - Then 0x03, addr 0x000010.
  - Required: `miso` returns 0xDEADBEEF, `wr_count`=1, `last_cmd`=0x03.
- Burst wrap:
  - With ADDR_W=8, write 0x11111111 and 0x22222222 from addr 0x0003FC.
  - Read 2 words from 0x0003FC → 0x11111111 then 0x22222222.
  - Read 1 word from 0x000000 → 0x22222222.
- Aborted write: raise `cs` after 20 data bits of 0x02 at addr 0x20 → `mem[8]` unchanged, `wr_count` unchanged, state `IDLE`.
- Unknown command: send 0x55 plus 32 clocks → `miso_oe`=0 throughout, `last_cmd`=0x55, no memory change.
- Reset mid-read: assert `rst` during the `RD` phase → the next cycle shows `miso`=0, `miso_oe`=0, `wr_count`=0, state `IDLE`; memory contents are retained.
- Read ID: 0x9F → `miso` gives 0xEF4016 with the macro defined; without it, `miso_oe` stays 0.
